// File: rtl/ahb_apb_bridge_pkg.sv
// Shared encodings and the byte-strobe helper for the AHB-lite to APB bridge.
package ahb_apb_bridge_pkg;

    // Bridge FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR1   = 3'd5;
    localparam logic [2:0] ST_ERR2   = 3'd6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Lane enables for a 32-bit bus; anything word-sized or larger lights all lanes.
    function automatic logic [3:0] strobe_gen(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/apb_slot_decode.sv
// Maps an AHB address onto a one-hot APB slot select; indices past the last slot flag a decode error.
module apb_slot_decode #(
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_SLOTS     = 16,
    parameter int SLOT_ADDR_LSB = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  valid,
    output logic [NUM_SLOTS-1:0]  psel,
    output logic                  decode_err
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [SLOT_W-1:0] idx;
    logic              unused_addr;

    // A single slot has no index field, so every address maps to slot 0.
    if (NUM_SLOTS > 1) begin : g_idx
        assign idx = addr[SLOT_ADDR_LSB +: SLOT_W];
    end else begin : g_single
        assign idx = '0;
    end

    assign unused_addr = ^addr;

    always_comb begin
        decode_err = valid && (32'(idx) >= 32'(NUM_SLOTS));
        psel       = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            psel[s] = valid && !decode_err && (32'(idx) == 32'(s));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_gen.sv
// AHB-lite slave to APB3/APB4 master bridge with slot decode, PREADY watchdog and error mapping.
module ahb_apb_bridge_gen
    import ahb_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SLOTS     = 16,
    parameter int SLOT_ADDR_LSB = 8,
    parameter int TIMEOUT       = 256,
    parameter int APB4_EN       = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSEL,
    input  logic [ADDR_WIDTH-1:0]     HADDR,
    input  logic                      HWRITE,
    input  logic [1:0]                HTRANS,
    input  logic [2:0]                HSIZE,
    input  logic [3:0]                HPROT,
    input  logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic                      HREADYIN,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [DATA_WIDTH-1:0]     HRDATA,
    output logic [NUM_SLOTS-1:0]      PSEL,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [2:0]                PPROT,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      TIMEOUT_EVT
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]            state_q, state_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic [NUM_SLOTS-1:0]  psel_q, psel_d;
    logic [NUM_SLOTS-1:0]  sel_q, sel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  timeout_evt_q, timeout_evt_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [1:0]            hprot_q, hprot_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept;
    logic                  timed_out;
    logic [NUM_SLOTS-1:0]  dec_psel;
    logic                  dec_err;
    logic                  unused_hprot;

    // Only the states that drive HREADYOUT high can take a new address phase.
    assign accept = HSEL && HREADYIN && hreadyout_q &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign timed_out    = (TIMEOUT > 0) && (32'(cnt_q) == 32'(TIMEOUT) - 32'd1);
    assign unused_hprot = ^HPROT[3:2];

    apb_slot_decode #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .NUM_SLOTS     (NUM_SLOTS),
        .SLOT_ADDR_LSB (SLOT_ADDR_LSB)
    ) u_slot_decode (
        .addr       (HADDR),
        .valid      (accept),
        .psel       (dec_psel),
        .decode_err (dec_err)
    );

    always_comb begin
        state_d       = state_q;
        hreadyout_d   = hreadyout_q;
        hresp_d       = hresp_q;
        hrdata_d      = hrdata_q;
        psel_d        = psel_q;
        sel_d         = sel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        hsize_d       = hsize_q;
        hprot_d       = hprot_q;
        timeout_evt_d = 1'b0;
        cnt_d         = '0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) begin
                    paddr_d     = HADDR;
                    pwrite_d    = HWRITE;
                    hsize_d     = HSIZE;
                    hprot_d     = HPROT[1:0];
                    sel_d       = dec_psel;
                    hreadyout_d = 1'b0;
                    // Empty slots skip the APB bus entirely and answer with ERROR.
                    state_d     = dec_err ? ST_ERR1 : ST_WDATA;
                    hresp_d     = dec_err ? HRESP_ERROR : HRESP_OKAY;
                end else begin
                    state_d     = ST_IDLE;
                    hreadyout_d = 1'b1;
                    hresp_d     = HRESP_OKAY;
                end
            end
            ST_WDATA: begin
                pwdata_d = HWDATA;
                pstrb_d  = (APB4_EN != 0 && pwrite_q) ? STRB_W'(strobe_gen(hsize_q, paddr_q[1:0])) : '0;
                pprot_d  = (APB4_EN != 0) ? {~hprot_q[0], 1'b0, hprot_q[1]} : 3'b000;
                psel_d   = sel_q;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY takes priority over a watchdog expiry in the same cycle.
                if (PREADY) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (PSLVERR) begin
                        state_d = ST_ERR1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d     = ST_DONE;
                        hreadyout_d = 1'b1;
                        hresp_d     = HRESP_OKAY;
                        if (!pwrite_q) hrdata_d = PRDATA;
                    end
                end else if (timed_out) begin
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    timeout_evt_d = 1'b1;
                    state_d       = ST_ERR1;
                    hresp_d       = HRESP_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= ST_IDLE;
            hreadyout_q   <= 1'b1;
            hresp_q       <= HRESP_OKAY;
            hrdata_q      <= '0;
            psel_q        <= '0;
            sel_q         <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            timeout_evt_q <= 1'b0;
            hsize_q       <= '0;
            hprot_q       <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            hreadyout_q   <= hreadyout_d;
            hresp_q       <= hresp_d;
            hrdata_q      <= hrdata_d;
            psel_q        <= psel_d;
            sel_q         <= sel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            timeout_evt_q <= timeout_evt_d;
            hsize_q       <= hsize_d;
            hprot_q       <= hprot_d;
            cnt_q         <= cnt_d;
        end
    end

    assign HREADYOUT   = hreadyout_q;
    assign HRESP       = hresp_q;
    assign HRDATA      = hrdata_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign TIMEOUT_EVT = timeout_evt_q;

endmodule

// File: tb/tb_ahb_apb_bridge_gen.sv
// Self-checking bench for ahb_apb_bridge_gen: the bench acts as AHB master and APB slave.
module tb_ahb_apb_bridge_gen;
    localparam int NSLOT = 12;
    localparam int TMO   = 8;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             HSEL;
    logic [31:0]      HADDR;
    logic             HWRITE;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic [3:0]       HPROT;
    logic [31:0]      HWDATA;
    logic             HREADYIN;
    logic             HREADYOUT;
    logic             HRESP;
    logic [31:0]      HRDATA;
    logic [NSLOT-1:0] PSEL;
    logic [31:0]      PADDR;
    logic             PWRITE;
    logic             PENABLE;
    logic [31:0]      PWDATA;
    logic [3:0]       PSTRB;
    logic [2:0]       PPROT;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic             TIMEOUT_EVT;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hrdata;

    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_gen #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLOTS(NSLOT),
        .SLOT_ADDR_LSB(8), .TIMEOUT(TMO), .APB4_EN(1)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMEOUT_EVT(TIMEOUT_EVT)
    );

    // One AHB transfer; starts and ends at a negedge where the bridge is ready.
    // The expected outcome is derived from the transfer's parameters alone.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input int waits, input logic slverr,
                        input logic [31:0] rdata, input logic [3:0] hprot, input logic stray);
        int slot, exp_wait, exp_pen, cyc, low, pen_cnt, psel_cnt, evt_cnt, acc;
        logic dec_err, tmo, err, done;
        logic [NSLOT-1:0] exp_psel;
        logic [3:0] exp_strb;
        logic [2:0] exp_prot;

        slot     = int'(addr[11:8]);
        dec_err  = (slot >= NSLOT);
        tmo      = !dec_err && (waits >= TMO);
        err      = dec_err || tmo || slverr;
        exp_wait = dec_err ? 1 : (tmo ? TMO + 3 : waits + 3 + (slverr ? 1 : 0));
        exp_pen  = dec_err ? 0 : (tmo ? TMO : waits + 1);
        exp_psel = '0;
        if (!dec_err) exp_psel[slot] = 1'b1;
        if (!wr)               exp_strb = 4'h0;
        else if (size == 3'd0) exp_strb = 4'b0001 << addr[1:0];
        else if (size == 3'd1) exp_strb = 4'b0011 << {addr[1], 1'b0};
        else                   exp_strb = 4'hF;
        exp_prot = {~hprot[0], 1'b0, hprot[1]};

        HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = 2'b10;
        HSIZE = size; HPROT = hprot; HREADYIN = 1'b1;
        @(posedge HCLK);
        cyc = 0; low = 0; pen_cnt = 0; psel_cnt = 0; evt_cnt = 0; acc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge HCLK);
            cyc++;
            HWDATA = (cyc == 1) ? wdata : $urandom;
            if (TIMEOUT_EVT) evt_cnt++;
            if (PSEL != '0) begin
                psel_cnt++;
                n_tests++;
                if (PSEL !== exp_psel) begin
                    n_fail++;
                    $display("FAIL psel addr=%h cyc=%0d got=%h exp=%h", addr, cyc, PSEL, exp_psel);
                end
                n_tests++;
                if ({PADDR, PWRITE, PWDATA, PSTRB, PPROT} !== {addr, wr, wdata, exp_strb, exp_prot}) begin
                    n_fail++;
                    $display("FAIL apb_ctl addr=%h cyc=%0d got paddr=%h pwrite=%b pwdata=%h pstrb=%h pprot=%h exp %h %b %h %h %h",
                             addr, cyc, PADDR, PWRITE, PWDATA, PSTRB, PPROT, addr, wr, wdata, exp_strb, exp_prot);
                end
            end
            if (PENABLE) begin
                pen_cnt++;
                acc++;
                PREADY  = (acc == waits + 1);
                PSLVERR = PREADY && slverr;
                PRDATA  = PREADY ? rdata : $urandom;
            end else begin
                PREADY  = 1'($urandom_range(0, 1));
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
            end
            if (HREADYOUT) begin
                done = 1'b1;
                if (!wr && !err) exp_hrdata = rdata;
                n_tests++;
                if (HRESP !== err) begin
                    n_fail++;
                    $display("FAIL hresp_final addr=%h got=%b exp=%b", addr, HRESP, err);
                end
                n_tests++;
                if (HRDATA !== exp_hrdata) begin
                    n_fail++;
                    $display("FAIL hrdata addr=%h got=%h exp=%h", addr, HRDATA, exp_hrdata);
                end
                HSEL = 1'b0; HTRANS = 2'b00;
            end else begin
                low++;
                n_tests++;
                if (HRESP !== (err && cyc == exp_wait)) begin
                    n_fail++;
                    $display("FAIL hresp_wait addr=%h cyc=%0d got=%b exp=%b", addr, cyc, HRESP, err && cyc == exp_wait);
                end
                if (stray) begin
                    HSEL = 1'b1; HTRANS = 2'b10; HADDR = $urandom; HWRITE = 1'($urandom_range(0, 1));
                end
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL no_response addr=%h got=none exp=HREADYOUT within 40 cycles", addr);
        end
        n_tests++;
        if (low != exp_wait) begin
            n_fail++;
            $display("FAIL wait_states addr=%h got=%0d exp=%0d", addr, low, exp_wait);
        end
        n_tests++;
        if (pen_cnt != exp_pen) begin
            n_fail++;
            $display("FAIL penable_cycles addr=%h got=%0d exp=%0d", addr, pen_cnt, exp_pen);
        end
        n_tests++;
        if (psel_cnt != (dec_err ? 0 : exp_pen + 1)) begin
            n_fail++;
            $display("FAIL psel_cycles addr=%h got=%0d exp=%0d", addr, psel_cnt, dec_err ? 0 : exp_pen + 1);
        end
        n_tests++;
        if (evt_cnt != (tmo ? 1 : 0)) begin
            n_fail++;
            $display("FAIL timeout_evt addr=%h got=%0d exp=%0d", addr, evt_cnt, tmo ? 1 : 0);
        end
    endtask

    // IDLE/BUSY cycles (sometimes with HSEL high) must leave the bridge ready and quiet.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            HSEL = 1'($urandom_range(0, 1)); HTRANS = 2'($urandom_range(0, 1)); HADDR = $urandom;
            @(posedge HCLK);
            @(negedge HCLK);
            n_tests++;
            if ({HREADYOUT, HRESP, (PSEL != '0), PENABLE} !== 4'b1000) begin
                n_fail++;
                $display("FAIL idle_okay got ready=%b resp=%b psel=%h penable=%b exp 1 0 0 0", HREADYOUT, HRESP, PSEL, PENABLE);
            end
        end
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        n_tests++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_hready got ready=%b resp=%b exp 1 0", HREADYOUT, HRESP);
        end
        n_tests++;
        if (HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hrdata got=%h exp=0", HRDATA);
        end
        n_tests++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, TIMEOUT_EVT} !== '0) begin
            n_fail++;
            $display("FAIL reset_apb got psel=%h pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h pprot=%h evt=%b exp all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, TIMEOUT_EVT);
        end
        HRESET = 1'b0;
        exp_hrdata = 32'h0;
    endtask

    task automatic test_write_slot3();
        xfer(32'h0000_0300, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 4'b0011, 1'b0);
        idle_gap(2);
    endtask

    task automatic test_read_waits();
        xfer(32'h0000_0500, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h1234_5678, 4'b0010, 1'b0);
        idle_gap(1);
    endtask

    task automatic test_slverr_back_to_back();
        xfer(32'h0000_0104, 1'b1, 3'd2, 32'hA5A5_0001, 1, 1'b1, 32'h0, 4'b0001, 1'b1);
        xfer(32'h0000_0A00, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 4'b0000, 1'b0);
        idle_gap(1);
    endtask

    task automatic test_timeout();
        xfer(32'h0000_0700, 1'b1, 3'd2, 32'h0BAD_0BAD, TMO + 2, 1'b0, 32'h0, 4'b0001, 1'b1);
        idle_gap(1);
        xfer(32'h0000_0704, 1'b0, 3'd2, 32'h0, TMO - 1, 1'b0, 32'h7777_1111, 4'b0001, 1'b0);
        idle_gap(1);
    endtask

    task automatic test_decode_and_strobe();
        xfer(32'h0000_0D00, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hFFFF_FFFF, 4'b0001, 1'b1);
        xfer(32'h0000_0402, 1'b1, 3'd1, 32'h5678_0000, 0, 1'b0, 32'h0, 4'b0011, 1'b0);
        xfer(32'h0000_0203, 1'b1, 3'd0, 32'h9900_0000, 2, 1'b0, 32'h0, 4'b0000, 1'b0);
        idle_gap(1);
    endtask

    task automatic test_reset_mid();
        int k;
        HSEL = 1'b1; HADDR = 32'h0000_0200; HWRITE = 1'b1; HTRANS = 2'b10;
        HSIZE = 3'd2; HPROT = 4'b0001;
        @(posedge HCLK);
        k = 0;
        PREADY = 1'b0;
        do begin
            @(negedge HCLK);
            HSEL = 1'b0; HTRANS = 2'b00; HWDATA = $urandom; PREADY = 1'b0;
            k++;
        end while (!PENABLE && k < 10);
        n_tests++;
        if (PENABLE !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reach_access got penable=%b exp=1", PENABLE);
        end
        HRESET = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        exp_hrdata = 32'h0;
        n_tests++;
        if ({(PSEL != '0), PENABLE, HREADYOUT, HRESP, TIMEOUT_EVT} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_mid got psel=%h pen=%b ready=%b resp=%b evt=%b exp 0 0 1 0 0",
                     PSEL, PENABLE, HREADYOUT, HRESP, TIMEOUT_EVT);
        end
        n_tests++;
        if (HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_hrdata got=%h exp=0", HRDATA);
        end
        xfer(32'h0000_0B08, 1'b0, 3'd2, 32'h0, 1, 1'b0, 32'h3141_5926, 4'b0010, 1'b0);
        idle_gap(1);
    endtask

    task automatic test_random();
        logic [3:0]  slot;
        logic [2:0]  size;
        logic [1:0]  lo;
        logic [31:0] addr;
        for (int i = 0; i < 80; i++) begin
            slot = 4'($urandom_range(0, 15));
            size = 3'($urandom_range(0, 2));
            lo   = 2'($urandom_range(0, 3));
            if (size == 3'd1) lo[0] = 1'b0;
            if (size == 3'd2) lo = 2'b00;
            addr = {20'($urandom), slot, 6'($urandom), lo};
            xfer(addr, 1'($urandom_range(0, 1)), size, $urandom, $urandom_range(0, 10),
                 ($urandom_range(0, 4) == 0), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
        end
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00;
        HSIZE = 3'd0; HPROT = 4'd0; HWDATA = '0; HREADYIN = 1'b1;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        exp_hrdata = '0;
        test_reset();
        test_write_slot3();
        test_read_waits();
        test_slverr_back_to_back();
        test_timeout();
        test_decode_and_strobe();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=still running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
